wbm_bridge: RTL and testbench

Wishbone controller that turns a byte stream into single Wishbone bus cycles and returns one reply byte per transaction. It sits between a serial byte receiver/transmitter pair (UART or SPI byte layer) and the on-chip Wishbone bus that carries peripherals such as the RGB LED block. It lets a host read and write peripheral registers.

---
 rtl/wb_pkg.sv | 23 ++
 rtl/wishbone.sv | 25 ++
 rtl/wbm_bridge.sv | 132 +++++++++++++
 tb/tb_wbm_bridge.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the Wishbone byte-stream bridge.
// Holds the bridge state encoding, reply byte values and command byte layout.
package wb_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DATA = 3'd1,
        STB  = 3'd2,
        WAIT = 3'd3,
        RESP = 3'd4
    } state_t;

    // Reply bytes returned to the host when the peripheral gives no read data
    localparam logic [7:0] REPLY_WR_OK      = 8'h00;
    localparam logic [7:0] REPLY_RD_TIMEOUT = 8'hFF;
    localparam logic [7:0] REPLY_WR_TIMEOUT = 8'h01;

    // Command byte layout: bit7 = we, bits6:4 reserved, bits3:0 = adr
    localparam int CMD_WE_BIT  = 7;
    localparam int CMD_ADR_MSB = 3;
    localparam int CMD_ADR_LSB = 0;

endpackage

// File: rtl/wishbone.sv
// wishbone: single-byte Wishbone bus bundle, including clock and reset.
// The bridge connects through the master modport; peripherals use slave.
interface wishbone;

    logic       clk;
    logic       rst;
    logic       stb;
    logic       we;
    logic [3:0] adr;
    logic       sel;
    logic [7:0] dat_c;
    logic [7:0] dat;
    logic       ack;

    modport master (
        input  clk, rst, dat, ack,
        output stb, we, adr, sel, dat_c
    );

    modport slave (
        input  clk, rst, stb, we, adr, sel, dat_c,
        output dat, ack
    );

endinterface

// File: rtl/wbm_bridge.sv
// wbm_bridge: turns a host byte stream into single Wishbone cycles and
// returns one reply byte per transaction (read data, or a write status).
// Optional feature macro: WBM_BRIDGE_TIMEOUT_EN -- aborts a cycle whose ack
// does not arrive within TIMEOUT WAIT cycles and replies with an error byte.
module wbm_bridge
    import wb_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    wishbone.master    wb,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy
);

    state_t     r_state;
    state_t     w_next;
    logic       r_we;
    logic [3:0] r_adr;
    logic [7:0] r_dat_c;
    logic [7:0] r_tx_data;
    logic       w_rx_fire;
    logic       w_timeout;
    logic [2:0] w_unused_rsvd;

    assign w_rx_fire     = rx_valid && rx_ready;
    assign w_unused_rsvd = rx_data[6:4];

`ifdef WBM_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;

    // WAIT-cycle counter: cleared while strobing, so it starts at 0 in WAIT
    always_ff @(posedge wb.clk) begin
        if (wb.rst) begin
            r_cnt <= '0;
        end else if (r_state == STB) begin
            r_cnt <= '0;
        end else if (r_state == WAIT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // The count reaches TIMEOUT on this cycle's increment
    assign w_timeout = (r_state == WAIT) && (r_cnt == CNT_W'(TIMEOUT - 1));
`else
    logic [31:0] w_unused_timeout;

    assign w_unused_timeout = TIMEOUT;
    assign w_timeout        = 1'b0;
`endif

    // State register
    always_ff @(posedge wb.clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // flop samples pre-edge values regardless of block ordering.
        if (wb.rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; ack only matters in WAIT, and ack beats the timeout
    always_comb begin
        // NOTE: default first so no path leaves w_next unassigned (no latch).
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_rx_fire) w_next = rx_data[CMD_WE_BIT] ? DATA : STB;
            DATA:    if (w_rx_fire) w_next = STB;
            STB:     w_next = WAIT;
            WAIT:    if (wb.ack || w_timeout) w_next = RESP;
            RESP:    if (tx_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Moore outputs decoded from state; rx_ready is also held low in reset
    always_comb begin
        rx_ready = 1'b0;
        tx_valid = 1'b0;
        wb.stb   = 1'b0;
        wb.sel   = 1'b0;
        busy     = (r_state != IDLE);
        case (r_state)
            IDLE:    rx_ready = !wb.rst;
            DATA:    rx_ready = !wb.rst;
            STB: begin
                wb.stb = 1'b1;
                wb.sel = 1'b1;
            end
            RESP:    tx_valid = 1'b1;
            default: ;
        endcase
    end

    // Command, write data and reply capture; these hold between transactions
    always_ff @(posedge wb.clk) begin
        if (wb.rst) begin
            r_we      <= 1'b0;
            r_adr     <= '0;
            r_dat_c   <= '0;
            r_tx_data <= '0;
        end else begin
            if (r_state == IDLE && w_rx_fire) begin
                r_we  <= rx_data[CMD_WE_BIT];
                r_adr <= rx_data[CMD_ADR_MSB:CMD_ADR_LSB];
            end
            if (r_state == DATA && w_rx_fire) begin
                r_dat_c <= rx_data;
            end
            if (r_state == WAIT) begin
                if (wb.ack) begin
                    r_tx_data <= r_we ? REPLY_WR_OK : wb.dat;
                end else if (w_timeout) begin
                    r_tx_data <= r_we ? REPLY_WR_TIMEOUT : REPLY_RD_TIMEOUT;
                end
            end
        end
    end

    assign wb.we    = r_we;
    assign wb.adr   = r_adr;
    assign wb.dat_c = r_dat_c;
    assign tx_data  = r_tx_data;

endmodule

// File: tb/tb_wbm_bridge.sv
// tb_wbm_bridge: directed and randomized transactions against a register-file
// peripheral; expected replies come from a shadow register array.
// Honours WBM_BRIDGE_TIMEOUT_EN for the timeout scenarios.
module tb_wbm_bridge;

    localparam int TB_TIMEOUT = 15;

    typedef struct packed {
        logic       we;
        logic [3:0] adr;
        logic [7:0] dat_c;
        logic       sel;
    } stb_rec_t;

    wishbone wb_if();

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;

    wbm_bridge #(.TIMEOUT(TB_TIMEOUT)) dut (
        .wb       (wb_if),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] seed_mem [16];
    logic [7:0] m_mem    [16];
    logic [7:0] p_mem    [16];

    logic       p_ack  = 1'b0;
    logic       f_ack  = 1'b0;
    logic [7:0] p_dat  = 8'h00;
    int         ack_dly = 1;
    bit         ack_en  = 1'b1;
    int         p_left  = 0;
    bit         p_pend  = 1'b0;
    logic [7:0] p_rdat  = 8'h00;
    logic       prev_stb = 1'b0;
    int         stb_wide = 0;
    stb_rec_t   stb_log [$];

    assign wb_if.ack = p_ack | f_ack;
    assign wb_if.dat = p_dat;

    initial begin
        wb_if.clk = 1'b0;
        forever #5 wb_if.clk = ~wb_if.clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
        $fatal(1, "watchdog expired");
    end

    // Register-file peripheral: logs strobes, acks ack_dly cycles after stb,
    // drives junk on dat whenever it is not acking.
    always @(negedge wb_if.clk) begin
        stb_rec_t rec;
        p_ack = 1'b0;
        p_dat = 8'($urandom);
        if (wb_if.rst) begin
            p_pend   = 1'b0;
            prev_stb = 1'b0;
            for (int i = 0; i < 16; i++) p_mem[i] = seed_mem[i];
        end else begin
            if (p_pend) begin
                p_left--;
                if (p_left == 0) begin
                    p_ack  = 1'b1;
                    p_dat  = p_rdat;
                    p_pend = 1'b0;
                end
            end
            if (wb_if.stb) begin
                rec.we    = wb_if.we;
                rec.adr   = wb_if.adr;
                rec.dat_c = wb_if.dat_c;
                rec.sel   = wb_if.sel;
                stb_log.push_back(rec);
                if (prev_stb) stb_wide++;
                p_rdat = p_mem[wb_if.adr];
                if (wb_if.we) p_mem[wb_if.adr] = wb_if.dat_c;
                p_left = ack_dly;
                p_pend = ack_en;
            end
            prev_stb = wb_if.stb;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete host transaction, entered and left at a negedge in IDLE
    task automatic run_txn(input bit we, input logic [3:0] adr, input logic [7:0] data,
                           input int dly, input bit aen, input int rdy_dly, input bit tie_rdy);
        int         base;
        int         n;
        int         exp_lat;
        logic [7:0] exp_reply;
        logic [7:0] held;
        bit         rx_bad;
        bit         busy_bad;
        bit         bp_bad;
        stb_rec_t   rec;

        base    = stb_log.size();
        ack_dly = dly;
        ack_en  = aen;
        exp_lat = dly + 2;
        exp_reply = we ? 8'h00 : m_mem[adr];
`ifdef WBM_BRIDGE_TIMEOUT_EN
        if (!aen || dly > TB_TIMEOUT) begin
            exp_lat   = TB_TIMEOUT + 2;
            exp_reply = we ? 8'h01 : 8'hFF;
        end
`endif
        if (we) m_mem[adr] = data;

        tx_ready = (rdy_dly == 0);
        rx_data  = {we, 3'($urandom), adr};
        rx_valid = 1'b1;
        chk("cmd_accept", rx_ready, 1);
        @(negedge wb_if.clk);
        if (we) begin
            rx_data = data;
            chk("data_ready", rx_ready, 1);
            @(negedge wb_if.clk);
        end
        // Junk stays offered; the bridge must not take it until IDLE
        rx_data  = 8'($urandom);
        n        = 1;
        rx_bad   = 1'b0;
        busy_bad = 1'b0;
        while (!tx_valid && n < 100) begin
            if (rx_ready !== 1'b0) rx_bad = 1'b1;
            if (busy !== 1'b1) busy_bad = 1'b1;
            @(negedge wb_if.clk);
            n++;
        end
        chk("latency", n, exp_lat);
        chk("rx_blocked", rx_bad, 0);
        chk("busy_during", busy_bad, 0);
        chk("reply", tx_data, exp_reply);

        held = tx_data;
        if (!tx_ready) begin
            bp_bad = 1'b0;
            for (int i = 1; i < rdy_dly; i++) begin
                @(negedge wb_if.clk);
                if (tx_valid !== 1'b1 || tx_data !== held || rx_ready !== 1'b0) bp_bad = 1'b1;
            end
            chk("backpressure", bp_bad, 0);
            tx_ready = 1'b1;
        end
        @(negedge wb_if.clk);
        chk("post_tx_valid", tx_valid, 0);
        chk("post_busy", busy, 0);
        chk("reaccept", rx_ready, 1);
        rx_valid = 1'b0;
        tx_ready = tie_rdy;

        chk("stb_count", stb_log.size(), base + 1);
        if (stb_log.size() > base) begin
            rec = stb_log[base];
            chk("stb_we", rec.we, we);
            chk("stb_adr", rec.adr, adr);
            chk("stb_sel", rec.sel, 1);
            if (we) chk("stb_dat_c", rec.dat_c, data);
        end
        chk("stb_width", stb_wide, 0);
    endtask

    initial begin
        int         hold;
        bit         bad;
        logic [3:0] a;

        for (int i = 0; i < 16; i++) seed_mem[i] = 8'($urandom);
        seed_mem[3] = 8'h5A;
        m_mem = seed_mem;

        wb_if.rst = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        tx_ready  = 1'b0;
        repeat (2) @(negedge wb_if.clk);

        // Reset values
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_stb", wb_if.stb, 0);
        chk("rst_we", wb_if.we, 0);
        chk("rst_sel", wb_if.sel, 0);
        chk("rst_adr", wb_if.adr, 0);
        chk("rst_dat_c", wb_if.dat_c, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_busy", busy, 0);
        wb_if.rst = 1'b0;
        @(negedge wb_if.clk);
        chk("idle_rx_ready", rx_ready, 1);

        // Directed read and write, then read back the written register
        run_txn(1'b0, 4'd3, 8'h00, 1, 1'b1, 0, 1'b0);
        run_txn(1'b1, 4'd2, 8'h01, 1, 1'b1, 1, 1'b0);
        run_txn(1'b0, 4'd2, 8'h00, 1, 1'b1, 2, 1'b0);

        // Ten cycles of downstream backpressure
        run_txn(1'b0, 4'($urandom), 8'h00, 1, 1'b1, 10, 1'b0);

        // Random mix of reads/writes, ack delays and tx_ready delays
        repeat (24) begin
            run_txn(1'($urandom), 4'($urandom), 8'($urandom),
                    $urandom_range(1, 6), 1'b1, $urandom_range(0, 3), 1'b0);
        end

        // Back-to-back reads of every address with tx_ready tied high
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) run_txn(1'b0, 4'(i), 8'h00, 1, 1'b1, 0, 1'b1);
        tx_ready = 1'b0;

`ifdef WBM_BRIDGE_TIMEOUT_EN
        run_txn(1'b0, 4'($urandom), 8'h00, 1, 1'b0, 0, 1'b0);
        run_txn(1'b1, 4'($urandom), 8'($urandom), 1, 1'b0, 1, 1'b0);
        run_txn(1'b0, 4'($urandom), 8'h00, TB_TIMEOUT, 1'b1, 0, 1'b0);
        run_txn(1'b1, 4'($urandom), 8'($urandom), TB_TIMEOUT, 1'b1, 0, 1'b0);
        hold = 5;
`else
        run_txn(1'b0, 4'($urandom), 8'h00, 30, 1'b1, 0, 1'b0);
        hold = 40;
`endif

        // Reset while stuck in WAIT, followed by a late ack
        ack_en   = 1'b0;
        a        = 4'($urandom);
        rx_data  = {4'h0, a};
        rx_valid = 1'b1;
        @(negedge wb_if.clk);
        rx_valid = 1'b0;
        bad = 1'b0;
        repeat (hold) begin
            @(negedge wb_if.clk);
            if (tx_valid !== 1'b0 || busy !== 1'b1) bad = 1'b1;
        end
        chk("wait_hold", bad, 0);
        wb_if.rst = 1'b1;
        @(negedge wb_if.clk);
        chk("mid_rst_stb", wb_if.stb, 0);
        chk("mid_rst_tx_valid", tx_valid, 0);
        chk("mid_rst_rx_ready", rx_ready, 0);
        wb_if.rst = 1'b0;
        f_ack     = 1'b1;
        @(negedge wb_if.clk);
        f_ack = 1'b0;
        chk("post_rst_rx_ready", rx_ready, 1);
        chk("post_rst_busy", busy, 0);
        bad = 1'b0;
        repeat (4) begin
            if (tx_valid !== 1'b0) bad = 1'b1;
            @(negedge wb_if.clk);
        end
        chk("late_ack_ignored", bad, 0);
        m_mem  = seed_mem;
        ack_en = 1'b1;

        // Normal operation resumes after the reset
        run_txn(1'b0, a, 8'h00, 1, 1'b1, 0, 1'b0);
        run_txn(1'b1, 4'($urandom), 8'($urandom), 2, 1'b1, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
